// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: line-idle sync, byte FIFO, threshold/timeout/overrun status
// Build option UART_RX_CTRL_OVERWRITE_EN: an overrun byte replaces the oldest entry instead of being dropped.
module uart_rx_ctrl #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int THRESH      = 8,
  parameter int SYNC_CYCLES = 16,
  parameter int TO_CYCLES   = 704
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_rx_line,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_load,
  output logic        o_rx_clear,
  input  logic        i_rd_en,
  output logic [7:0]  o_rd_data,
  output logic        o_empty,
  output logic        o_full,
  output logic [AW:0] o_level,
  output logic        o_thresh_irq,
  output logic        o_timeout_irq,
  output logic        o_overrun,
  input  logic        i_ovr_clr
);

  localparam int SW = $clog2(SYNC_CYCLES + 1);
  localparam int TW = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_SYNC = 2'd1, ST_RUN = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_sync_cnt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic [TW-1:0] r_to_cnt;
  logic          r_overrun;
  logic [7:0]    r_rd_data;

  logic w_flush, w_run, w_full, w_empty, w_sync_done;
  logic w_wr, w_rd, w_ovr_evt, w_ovw, w_to_max;

  assign w_run       = (r_state == ST_RUN);
  assign w_flush     = !i_enable || (r_state == ST_OFF);
  assign w_full      = (r_level == (AW+1)'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_sync_done = i_rx_line && (r_sync_cnt == SW'(SYNC_CYCLES - 1));
  assign w_to_max    = (r_to_cnt == TW'(TO_CYCLES - 1));

  // A pop frees a slot in the same cycle, so a push at Full is legal alongside RdEn.
  assign w_wr      = !w_flush && w_run && i_rx_load && (!w_full || i_rd_en);
  assign w_rd      = !w_flush && i_rd_en && !w_empty;
  assign w_ovr_evt = !w_flush && w_run && i_rx_load && w_full && !i_rd_en;

`ifdef UART_RX_CTRL_OVERWRITE_EN
  assign w_ovw = w_ovr_evt;
`else
  assign w_ovw = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:  w_state_nxt = ST_SYNC;
      ST_SYNC: if (w_sync_done) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_OFF;
    endcase
    if (!i_enable) w_state_nxt = ST_OFF;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_OFF;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_sync_cnt <= '0;
    else if (r_state != ST_SYNC || !i_rx_line) r_sync_cnt <= '0;
    else                                       r_sync_cnt <= r_sync_cnt + SW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (w_wr || w_ovw) r_mem[r_wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_data <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr || w_ovw) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd || w_ovw) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_rd)          r_rd_data <= r_mem[r_rd_ptr];
      if (w_wr && !w_rd)      r_level <= r_level + (AW+1)'(1);
      else if (w_rd && !w_wr) r_level <= r_level - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_overrun <= 1'b0;
    else if (w_flush)   r_overrun <= 1'b0;
    else if (w_ovr_evt) r_overrun <= 1'b1;
    else if (i_ovr_clr) r_overrun <= 1'b0;
  end

  // Saturates at the terminal value so the irq stays up until something clears the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                    r_to_cnt <= '0;
    else if (w_flush || i_rx_load || w_rd || w_empty) r_to_cnt <= '0;
    else if (w_run && !w_to_max)                      r_to_cnt <= r_to_cnt + TW'(1);
  end

  assign o_rx_clear    = !w_run;
  assign o_rd_data     = r_rd_data;
  assign o_empty       = w_empty;
  assign o_full        = w_full;
  assign o_level       = r_level;
  assign o_thresh_irq  = (r_level >= (AW+1)'(THRESH));
  assign o_timeout_irq = w_to_max;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl: vector table, corner sequences, random vs queue model
module tb_uart_rx_ctrl;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;
  localparam int SYNC   = 16;
  localparam int TO     = 704;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, line = 1'b1, load = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [7:0] data = 8'h00;

  logic       rx_clear, empty, full, thresh, tmo, ovr;
  logic [7:0] rd_data;
  logic [4:0] level;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_rx_line(line),
    .i_rx_data(data), .i_rx_load(load), .o_rx_clear(rx_clear), .i_rd_en(rd),
    .o_rd_data(rd_data), .o_empty(empty), .o_full(full), .o_level(level),
    .o_thresh_irq(thresh), .o_timeout_irq(tmo), .o_overrun(ovr), .i_ovr_clr(clr)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural reference: mode 0=off 1=sync 2=run, contents as a plain queue.
  int         m_mode = 0, m_sync = 0, m_to = 0;
  bit         m_ovr = 1'b0;
  logic [7:0] m_rd = 8'h00;
  logic [7:0] q[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit f, e, pop, push, ov;
    f = (q.size() == DEPTH);
    e = (q.size() == 0);
    if (!en) begin
      m_mode = 0; q.delete(); m_ovr = 1'b0; m_to = 0; m_sync = 0;
      return;
    end
    case (m_mode)
      0: begin m_mode = 1; m_sync = 0; end
      1: begin
        if (!line)               m_sync = 0;
        else if (m_sync == SYNC-1) m_mode = 2;
        else                     m_sync++;
      end
      default: begin
        pop  = rd && !e;
        push = load && (!f || rd);
        ov   = load && f && !rd;
        if (load || pop || e) m_to = 0;
        else if (m_to < TO-1) m_to++;
        if (pop)  m_rd = q.pop_front();
        if (push) q.push_back(data);
        if (ov) begin
          m_ovr = 1'b1;
`ifdef UART_RX_CTRL_OVERWRITE_EN
          void'(q.pop_front());
          q.push_back(data);
`endif
        end else if (clr) m_ovr = 1'b0;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    chk("m_clear",  rx_clear, (m_mode != 2));
    chk("m_level",  level,    q.size());
    chk("m_empty",  empty,    (q.size() == 0));
    chk("m_full",   full,     (q.size() == DEPTH));
    chk("m_thresh", thresh,   (q.size() >= THRESH));
    chk("m_tmo",    tmo,      (m_to == TO-1));
    chk("m_ovr",    ovr,      m_ovr);
    chk("m_rddata", rd_data,  m_rd);
  endtask

  task automatic cyc(input bit ld, input logic [7:0] d, input bit r, input bit c);
    load = ld; data = d; rd = r; clr = c;
    tick();
    load = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic go_run(input int exp_n, input string nm);
    int n = 0;
    while (rx_clear && n < 40) begin tick(); n++; end
    chk(nm, n, exp_n);
  endtask

  typedef struct {
    bit         ld;
    logic [7:0] d;
    bit         r;
    int         lvl;
    bit         emp;
    logic [7:0] rdd;
  } vec_t;

  vec_t       tbl[9];
  logic [7:0] exp_q[$];

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 8'h11};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h22};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h33};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h33};
    tbl[7] = '{1'b1, 8'h44, 1'b1, 1, 1'b0, 8'h33};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h44};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_clear", rx_clear, 1);
    chk("rst_rddata", rd_data, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_irqs", {thresh, tmo, ovr}, 0);
    rst_n = 1'b1;

    en = 1'b1; line = 1'b1;
    tick();
    go_run(SYNC, "sync_len");

    en = 1'b0; tick();
    en = 1'b1; tick();
    repeat (10) tick();
    line = 1'b0; tick();
    line = 1'b1;
    go_run(SYNC, "sync_restart");

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].ld, tbl[i].d, tbl[i].r, 1'b0);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].emp);
      chk($sformatf("vec%0d_rddata", i), rd_data, tbl[i].rdd);
    end

    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      chk($sformatf("thr_push%0d", i), thresh, (i == 7));
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("thr_pop", thresh, 0);
    repeat (7) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("thr_drained", empty, 1);

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", full, 1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovr_set", ovr, 1);
    chk("ovr_level", level, 16);
    cyc(1'b1, 8'hBB, 1'b0, 1'b1);
    chk("ovr_set_wins", ovr, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_clr", ovr, 0);
    exp_q.delete();
`ifdef UART_RX_CTRL_OVERWRITE_EN
    for (int i = 2; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
`else
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
`endif
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("ovr_pop%0d", i), rd_data, exp_q[i]);
    end
    chk("ovr_drained", empty, 1);

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullrw_ovr", ovr, 0);
    chk("fullrw_level", level, 16);
    chk("fullrw_rd", rd_data, 8'h60);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("fullrw_pop%0d", i), rd_data, 8'h60 + i);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullrw_last", rd_data, 8'h55);

    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    repeat (TO - 2) tick();
    chk("tmo_before", tmo, 0);
    tick();
    chk("tmo_hit", tmo, 1);
    tick();
    chk("tmo_hold", tmo, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("tmo_pop", tmo, 0);
    chk("tmo_pop_data", rd_data, 8'h77);

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("dis_pre_ovr", ovr, 1);
    en = 1'b0; load = 1'b1; data = 8'h99;
    tick();
    load = 1'b0;
    chk("dis_clear", rx_clear, 1);
    chk("dis_level", level, 0);
    chk("dis_ovr", ovr, 0);

    en = 1'b1; line = 1'b1;
    tick();
    go_run(SYNC, "sync_rand");
    for (int i = 0; i < 3000; i++) begin
      bit fill_phase;
      fill_phase = ((i / 200) % 2) == 0;
      en   = ($urandom_range(0, 499) != 0);
      line = ($urandom_range(0, 15) != 0);
      load = fill_phase ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
      rd   = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
